// File: rtl/fifo_multi_line_buffer.sv
// Multi-line circular buffer: NUM_LINES line RAMs sharing one column pointer,
// presenting a vertical column of NUM_LINES+1 taps. Optional macro: LINE_BUF_ZERO_MASK_EN.
module fifo_multi_line_buffer #(
  parameter  int DATA_W    = 8,
  parameter  int LINE_W    = 640,
  parameter  int NUM_LINES = 2,
  localparam int PTR_W     = $clog2(LINE_W)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we_i,
  input  logic                            flush_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic [(NUM_LINES+1)*DATA_W-1:0] taps_o,
  output logic                            valid_o,
  output logic                            done_o,
  output logic                            line_end_o,
  output logic [PTR_W-1:0]                col_o
);

  localparam int CNT_W = $clog2(NUM_LINES + 1);
  localparam int TAP_W = (NUM_LINES + 1) * DATA_W;

  logic [PTR_W-1:0]  ptr_r;
  logic [CNT_W-1:0]  line_cnt_r;
  logic [TAP_W-1:0]  taps_r;
  logic              valid_r;
  logic              done_r;
  logic              line_end_r;
  logic [PTR_W-1:0]  col_r;

  logic              wr_en_s;
  logic              wrap_s;
  logic [TAP_W-1:0]  taps_next_s;
  logic [DATA_W-1:0] rd_s [NUM_LINES];

  // RAM is frozen while reset is held so a held write cannot shift stale lines
  assign wr_en_s = rst & we_i & ~flush_i;
  assign wrap_s  = (ptr_r == PTR_W'(LINE_W - 1));

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [DATA_W-1:0] mem_r [LINE_W];
    logic [DATA_W-1:0] wdata_s;

    assign rd_s[g] = mem_r[ptr_r];

    if (g == 0) begin : g_first
      assign wdata_s = data_i;
    end else begin : g_chain
      assign wdata_s = rd_s[g-1];
    end

    // Single-port line RAM: read-before-write at the shared pointer
    always_ff @(posedge clk) begin
      if (wr_en_s) begin
        mem_r[ptr_r] <= wdata_s;
      end
    end
  end

  // Next tap column: newest pixel at tap 0, older lines above it
  always_comb begin
    taps_next_s = '0;
    taps_next_s[0 +: DATA_W] = data_i;
    for (int k = 1; k <= NUM_LINES; k++) begin
`ifdef LINE_BUF_ZERO_MASK_EN
      if (line_cnt_r < CNT_W'(k)) begin
        taps_next_s[k*DATA_W +: DATA_W] = '0;
      end else begin
        taps_next_s[k*DATA_W +: DATA_W] = rd_s[k-1];
      end
`else
      taps_next_s[k*DATA_W +: DATA_W] = rd_s[k-1];
`endif
    end
  end

  // Pointer, fill state and registered outputs; flush outranks a write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r      <= '0;
      line_cnt_r <= '0;
      taps_r     <= '0;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
      line_end_r <= 1'b0;
      col_r      <= '0;
    end else if (flush_i) begin
      ptr_r      <= '0;
      line_cnt_r <= '0;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
      line_end_r <= 1'b0;
    end else if (we_i) begin
      taps_r     <= taps_next_s;
      col_r      <= ptr_r;
      valid_r    <= 1'b1;
      line_end_r <= wrap_s;
      ptr_r      <= wrap_s ? '0 : ptr_r + PTR_W'(1);
      if (wrap_s && (line_cnt_r != CNT_W'(NUM_LINES))) begin
        line_cnt_r <= line_cnt_r + CNT_W'(1);
      end
      if (line_cnt_r == CNT_W'(NUM_LINES)) begin
        done_r <= 1'b1;
      end
    end else begin
      valid_r    <= 1'b0;
      line_end_r <= 1'b0;
    end
  end

  assign taps_o     = taps_r;
  assign valid_o    = valid_r;
  assign done_o     = done_r;
  assign line_end_o = line_end_r;
  assign col_o      = col_r;

endmodule

// File: tb/tb_fifo_multi_line_buffer.sv
// Directed self-checking bench for fifo_multi_line_buffer (LINE_W=4, NUM_LINES=2).
module tb_fifo_multi_line_buffer;

  localparam int DATA_W    = 8;
  localparam int LINE_W    = 4;
  localparam int NUM_LINES = 2;
  localparam int PTR_W     = $clog2(LINE_W);
  localparam int TAP_W     = (NUM_LINES + 1) * DATA_W;

  logic              clk;
  logic              rst;
  logic              we_i;
  logic              flush_i;
  logic [DATA_W-1:0] data_i;
  logic [TAP_W-1:0]  taps_o;
  logic              valid_o;
  logic              done_o;
  logic              line_end_o;
  logic [PTR_W-1:0]  col_o;

  int errors = 0;
  int checks = 0;

  fifo_multi_line_buffer #(
    .DATA_W(DATA_W), .LINE_W(LINE_W), .NUM_LINES(NUM_LINES)
  ) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .flush_i(flush_i), .data_i(data_i),
    .taps_o(taps_o), .valid_o(valid_o), .done_o(done_o),
    .line_end_o(line_end_o), .col_o(col_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: drive on negedge, sample 1 time unit after posedge
  task automatic step(input logic we, input logic fl, input int d);
    @(negedge clk);
    we_i    = we;
    flush_i = fl;
    data_i  = DATA_W'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; we_i = 1'b0; flush_i = 1'b0; data_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({taps_o, valid_o, done_o, line_end_o, col_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got taps=%h v=%b d=%b le=%b col=%0d, want all zero",
               taps_o, valid_o, done_o, line_end_o, col_o);
    end
  endtask

  task automatic test_continuous();
    logic [TAP_W-1:0] exp_t;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, i);
      checks++;
      if (valid_o !== 1'b1 || line_end_o !== (i % 4 == 0) || col_o !== PTR_W'((i - 1) % 4)
          || done_o !== (i >= 9) || taps_o[DATA_W-1:0] !== DATA_W'(i)) begin
        errors++;
        $display("FAIL cont_ctrl[%0d]: got v=%b le=%b col=%0d d=%b t0=%0d", i,
                 valid_o, line_end_o, col_o, done_o, taps_o[DATA_W-1:0]);
      end
      if (i >= 9) begin
        exp_t = {DATA_W'(i - 8), DATA_W'(i - 4), DATA_W'(i)};
        checks++;
        if (taps_o !== exp_t) begin
          errors++;
          $display("FAIL cont_taps[%0d]: got %h want %h", i, taps_o, exp_t);
        end
      end
    end
    step(1'b0, 1'b0, 99);
    checks++;
    if (valid_o !== 1'b0 || line_end_o !== 1'b0 || taps_o !== {8'd4, 8'd8, 8'd12}
        || col_o !== 2'd3 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL cont_idle: got v=%b le=%b taps=%h col=%0d d=%b",
               valid_o, line_end_o, taps_o, col_o, done_o);
    end
  endtask

  task automatic test_gap();
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, i);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 77);
      checks++;
      if (valid_o !== 1'b0 || col_o !== 2'd1 || taps_o[DATA_W-1:0] !== 8'd6
          || taps_o[2*DATA_W-1:DATA_W] !== 8'd2) begin
        errors++;
        $display("FAIL gap_hold[%0d]: got v=%b col=%0d taps=%h", g, valid_o, col_o, taps_o);
      end
    end
    for (int i = 7; i <= 12; i++) step(1'b1, 1'b0, i);
    checks++;
    if (taps_o !== {8'd4, 8'd8, 8'd12} || done_o !== 1'b1 || col_o !== 2'd3) begin
      errors++;
      $display("FAIL gap_final: got taps=%h d=%b col=%0d want 04080c/1/3", taps_o, done_o, col_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, i);
    step(1'b1, 1'b1, 11);
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b0 || line_end_o !== 1'b0
        || taps_o !== {8'd2, 8'd6, 8'd10}) begin
      errors++;
      $display("FAIL flush_drop: got v=%b d=%b le=%b taps=%h want 0/0/0/02060a",
               valid_o, done_o, line_end_o, taps_o);
    end
    for (int i = 21; i <= 28; i++) step(1'b1, 1'b0, i);
    checks++;
    if (done_o !== 1'b0 || col_o !== 2'd3 || line_end_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_done: got d=%b col=%0d le=%b want 0/3/1", done_o, col_o, line_end_o);
    end
    step(1'b1, 1'b0, 29);
    checks++;
    if (done_o !== 1'b1 || taps_o !== {8'd21, 8'd25, 8'd29} || col_o !== 2'd0) begin
      errors++;
      $display("FAIL flush_refill: got d=%b taps=%h col=%0d want 1/15191d/0", done_o, taps_o, col_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, i);
    @(negedge clk);
    we_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({taps_o, valid_o, done_o, line_end_o, col_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got taps=%h v=%b d=%b le=%b col=%0d, want all zero",
               taps_o, valid_o, done_o, line_end_o, col_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, i);
    checks++;
    if (done_o !== 1'b0 || col_o !== 2'd3) begin
      errors++;
      $display("FAIL async_pre_done: got d=%b col=%0d want 0/3", done_o, col_o);
    end
    step(1'b1, 1'b0, 9);
    checks++;
    if (taps_o !== {8'd1, 8'd5, 8'd9} || col_o !== 2'd0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL async_refill: got taps=%h col=%0d d=%b want 010509/0/1", taps_o, col_o, done_o);
    end
  endtask

`ifdef LINE_BUF_ZERO_MASK_EN
  task automatic test_mask();
    do_reset();
    step(1'b1, 1'b0, 1);
    checks++;
    if (taps_o !== {8'd0, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL mask_w1: got %h want 000001", taps_o);
    end
    for (int i = 2; i <= 5; i++) step(1'b1, 1'b0, i);
    checks++;
    if (taps_o !== {8'd0, 8'd1, 8'd5}) begin
      errors++;
      $display("FAIL mask_w5: got %h want 000105", taps_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; we_i = 1'b0; flush_i = 1'b0; data_i = '0;
    test_reset();
    test_continuous();
    test_gap();
    test_flush();
    test_async_reset();
`ifdef LINE_BUF_ZERO_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_multi_line_buffer.md
Name: fifo_multi_line_buffer

Overview:
Parametrised successor of the single-line FIFO buffer for the Sobel pipeline. Stores NUM_LINES full image lines in circular RAMs sharing one pointer. Presents one vertical column of NUM_LINES+1 samples per accepted pixel: the current pixel plus the same column from each earlier line. Sits between the pixel source and the 3x3 window/Sobel kernel; the default NUM_LINES=2 gives the 3-row column.

Parameters:
DATA_W, 8, pixel width in bits
LINE_W, 640, pixels per image line; must be >= 2
NUM_LINES, 2, number of stored (delayed) lines; must be >= 1
PTR_W, $clog2(LINE_W), localparam, width of column pointer

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
we_i  input  1  write enable; one pixel accepted per cycle when high
flush_i  input  1  synchronous clear of pointer/fill state; higher priority than we_i
data_i  input  DATA_W  pixel in
taps_o  output  (NUM_LINES+1)*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; tap 0 = newest pixel, tap k = pixel written k*LINE_W writes earlier
valid_o  output  1  taps_o updated by a write on the previous edge
done_o  output  1  level: NUM_LINES full lines stored, all taps meaningful
line_end_o  output  1  one-cycle pulse: previous write was last pixel of a line
col_o  output  PTR_W  column of the pixel currently on tap 0

Behaviour:
- Reset (rst=0, async): ptr=0, fill count=0, taps_o=0, valid_o=0, done_o=0, line_end_o=0, col_o=0. RAM contents not cleared.
- Write (we_i=1, flush_i=0): read-before-write at ptr across all line RAMs.
  - Line 0 RAM[ptr] <= data_i.
  - Line k RAM[ptr] <= old line k-1 RAM[ptr].
  - taps_o <= {old line NUM_LINES-1 RAM[ptr], ..., old line 0 RAM[ptr], data_i}.
  - col_o <= ptr.
  - ptr wraps LINE_W-1 -> 0, else increments.
- Latency: exactly 1 cycle from accepted write to taps_o/valid_o/col_o.
- valid_o = registered we_i & ~flush_i.
- line_end_o = 1 the cycle after a write with ptr==LINE_W-1.
- Idle (we_i=0): RAM, ptr and taps_o hold; valid_o=0, line_end_o=0.
- Fill state: line counter 0..NUM_LINES, increments on each line wrap and saturates at NUM_LINES.
- done_o goes 1 on the edge of the first write made with line counter==NUM_LINES. First such write is write index NUM_LINES*LINE_W (0-based). done_o stays 1 until flush or reset.
- flush_i=1: ptr=0, line counter=0, done_o=0, valid_o=0, line_end_o=0. taps_o and RAM are left unchanged. Any write in the same cycle is dropped.
- Reset mid-line: fully discards progress; the next write goes to column 0.
- RAM is inferable as one block RAM per line (single read/write port at ptr); no other RAM access paths.

Optional Feature:
Macro LINE_BUF_ZERO_MASK_EN.
- Defined: any tap k (k>=1) whose line has not been stored yet (line counter < k at the write) is forced to 0. Tap 0 is never masked. Taps before done_o are deterministic zeros.
- Undefined: no masking; unprimed taps carry raw RAM contents (X in simulation), and consumers must qualify on done_o.

Test Plan:
- LINE_W=4, NUM_LINES=2, reset then write 1..12 continuously -> after 9th write (data 9): taps {1,5,9}, col_o=0, done_o rises same cycle; after 12th write: taps {4,8,12}.
- Same stimulus -> line_end_o pulses exactly the cycles after writes 4, 8, 12. valid_o is high for 12 consecutive cycles.
- Write 1..6, drop we_i for 3 cycles, resume 7..12 -> taps_o/col_o hold during the gap with valid_o=0; final taps {4,8,12}, identical to the continuous run.
- Write 1..10, assert flush_i together with we_i (data 11) -> write dropped, done_o=0, valid_o=0. Next writes 21..29 -> done_o rises after data 29; taps {21,25,29}.
- Assert rst low mid-line (after data 6) asynchronously between edges -> outputs 0 immediately. After release, writes 1..9 give taps {1,5,9}.
- With LINE_BUF_ZERO_MASK_EN: reset, write 1..5 -> after write 5, taps {0,1,5}. After write 1: taps {0,0,1}, not X.
